seq_div32: RTL
==============

Name: seq_div32

Overview:
- Multi-cycle restoring divider for MIPS DIV/DIVU. It is the iterative shift-subtract counterpart of the combinational add/sub datapath.
- Sits beside the ALU in EX and writes HI (remainder) and LO (quotient).
- Uses a start/busy/done handshake. The pipeline stalls on busy.

Parameters:
- WIDTH, 32: operand, quotient and remainder width.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while idle (busy=0).
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  in  WIDTH  captured when start is accepted.
- divisor  in  WIDTH  captured when start is accepted.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- quotient  out  WIDTH  LO value; held until the next accepted start.
- remainder  out  WIDTH  HI value; held until the next accepted start.
- div_zero  out  1  divisor was 0; held with the results.

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE, busy=0, done=0, div_zero=0, quotient=0, remainder=0, counter=0.
  - Reset during CALC aborts the operation; no done pulse follows.
- States:
  - IDLE: start=1 latches operands and is_signed, clears quotient, remainder and div_zero, then moves to CALC (or FIX for zero divisor or early-out). busy=1 next cycle.
  - CALC: one restoring step per cycle.
    - partial remainder = {rem[WIDTH-2:0], dq[WIDTH-1]}.
    - If partial remainder >= |divisor|: subtract and shift in 1. Else shift in 0.
    - Counter goes from 0 to WIDTH-1. After WIDTH steps, move to FIX.
  - FIX: apply signs and register the outputs, then move to IDLE. In the next cycle done=1 and busy=0.
- Signed mode:
  - Operate on magnitudes.
  - quotient sign = dividend[31] ^ divisor[31].
  - remainder sign = dividend sign. The remainder of a zero-magnitude result stays 0.
- Latency, start accepted at edge k:
  - Normal divide: done is high in the cycle after edge k+WIDTH+1, which is 34 cycles for WIDTH=32.
  - Divisor 0: IDLE goes straight to FIX. done is high after edge k+1. quotient=all-ones, remainder=dividend (raw), div_zero=1.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, div_zero=0. No flag; matches MIPS wrap.
- start while busy=1 is ignored.
- Back-to-back operation: start in the done cycle is accepted, because state is IDLE. The previous results stay on the outputs until that acceptance edge.
- Operand inputs may change freely after acceptance.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if divisor != 0 and |divisor| > |dividend|, go directly to FIX.
  - quotient=0, remainder=dividend (raw, sign preserved).
  - done after 2 cycles.
- Undefined: these cases take the full WIDTH iterations. Results are identical either way; only latency differs.

Decomposition:
- Shared package div_pkg holds:
  - the state encoding: IDLE, CALC, FIX;
  - WIDTH_DEFAULT=32;
  - DIV0_QUOTIENT = all-ones constant;
  - an abs/negate helper function.
- One sub-module: div_step, a combinational restoring iteration.
  - Inputs: rem, dq, divisor_mag.
  - Outputs: next rem, next dq.
- The top level holds the FSM, counter, operand registers and sign fix.

Test Plan:
- DIVU 100/7, start 1 cycle → busy high 33 cycles; done at cycle 34; quotient=14, remainder=2.
- DIV -7/2 (0xFFFFFFF9 / 2) → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV 7/-2 → quotient=-3, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, div_zero=0. DIVU 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
- Divisor 0, dividend 0x1234 → done 2 cycles after start, quotient=0xFFFFFFFF, remainder=0x1234, div_zero=1.
- Reset asserted at iteration 10 → busy=0 and all outputs 0 immediately (asynchronous); no done pulse. A new start after reset completes correctly.
- Pulse start during busy, then again in the done cycle → mid-run start is ignored; the done-cycle start is accepted. With DIV_EARLY_OUT_EN, DIVU 3/10 → done at cycle 2, quotient=0, remainder=3.

Source files
------------

// File: rtl/div_pkg.sv
// Shared state encoding, constants and sign helper for the seq_div32 restoring divider.
// Optional early-out path is enabled by DIV_EARLY_OUT_EN (see seq_div32).
package div_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } div_state_t;

   localparam int WIDTH_DEFAULT = 32;
   localparam int MAX_W         = 64;

   localparam logic [MAX_W-1:0] DIV0_QUOTIENT = '1;

   // Negate in two's complement when neg is set; callers zero-extend in and truncate out.
   function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v, input logic neg);
      return neg ? (~v + MAX_W'(1)) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// subtract the divisor magnitude when it fits, and shift the quotient bit into dq.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
)(
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] dq,
   input  logic [WIDTH-1:0] divisor_mag,
   output logic [WIDTH-1:0] rem_nxt,
   output logic [WIDTH-1:0] dq_nxt
);

   // One extra bit keeps the shifted remainder exact when the divisor magnitude has its MSB set.
   logic [WIDTH:0]   w_partial;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

   assign w_partial = {rem, dq[WIDTH-1]};
   assign w_ge      = (w_partial >= {1'b0, divisor_mag});
   assign w_diff    = w_partial[WIDTH-1:0] - divisor_mag;
   assign rem_nxt   = w_ge ? w_diff : w_partial[WIDTH-1:0];
   assign dq_nxt    = {dq[WIDTH-2:0], w_ge};

endmodule

// File: rtl/seq_div32.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU (LO=quotient, HI=remainder), start/busy/done.
// Define DIV_EARLY_OUT_EN to finish in two cycles when |divisor| > |dividend|.
module seq_div32
   import div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int CNT_W = 6
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   div_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem, r_dq, r_dvs_mag, r_dividend;
   logic [WIDTH-1:0] r_quotient, r_remainder;
   logic             r_q_neg, r_r_neg, r_div0, r_bypass, r_done, r_div_zero;

   logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_rem_nxt, w_dq_nxt;
   logic             w_dvs_zero, w_early, w_accept, w_last;

   assign w_dvd_mag  = WIDTH'(cond_neg(MAX_W'(dividend), is_signed & dividend[WIDTH-1]));
   assign w_dvs_mag  = WIDTH'(cond_neg(MAX_W'(divisor),  is_signed & divisor[WIDTH-1]));
   assign w_dvs_zero = (divisor == '0);
   assign w_accept   = (r_state == S_IDLE) && start;
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
   assign w_early = !w_dvs_zero && (w_dvs_mag > w_dvd_mag);
`else
   assign w_early = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem         (r_rem),
      .dq          (r_dq),
      .divisor_mag (r_dvs_mag),
      .rem_nxt     (w_rem_nxt),
      .dq_nxt      (w_dq_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_state_nxt = (w_dvs_zero || w_early) ? S_FIX : S_CALC;
         S_CALC:  if (w_last) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_dq        <= '0;
         r_dvs_mag   <= '0;
         r_dividend  <= '0;
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_div0      <= 1'b0;
         r_bypass    <= 1'b0;
         r_done      <= 1'b0;
         r_div_zero  <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else begin
         r_done <= (r_state == S_FIX);
         if (w_accept) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dq        <= w_dvd_mag;
            r_dvs_mag   <= w_dvs_mag;
            r_dividend  <= dividend;
            r_q_neg     <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_r_neg     <= is_signed & dividend[WIDTH-1];
            r_div0      <= w_dvs_zero;
            r_bypass    <= w_dvs_zero | w_early;
            r_div_zero  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
         end else if (r_state == S_CALC) begin
            r_rem <= w_rem_nxt;
            r_dq  <= w_dq_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (r_state == S_FIX) begin
            // Bypassed operations leave the dividend untouched as the remainder.
            if (r_bypass) begin
               r_quotient  <= r_div0 ? WIDTH'(DIV0_QUOTIENT) : '0;
               r_remainder <= r_dividend;
            end else begin
               r_quotient  <= WIDTH'(cond_neg(MAX_W'(r_dq),  r_q_neg));
               r_remainder <= WIDTH'(cond_neg(MAX_W'(r_rem), r_r_neg));
            end
            r_div_zero <= r_div0;
         end
      end
   end

   assign done      = r_done;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign div_zero  = r_div_zero;

endmodule
